m_xnor_vec_cmp: RTL and testbench

Parametrised, pipelined vector XNOR/XOR comparator. It is the sequential successor to the single-bit XNOR cell. Each accepted input word is compared bitwise against a programmable pattern under a mask, and the block reports:
- the number of agreeing (or differing) bits,
- a threshold hit flag,
- a saturating hit counter.

It sits in the datapath between a valid/ready producer and consumer, e.g. for sync-word detection and correlation in the std-cell/IP layer.

---
 rtl/m_xnor_pkg.sv | 14 +
 rtl/m_popcount.sv | 38 +++
 rtl/m_xnor_vec_cmp.sv | 137 +++++++++++++
 tb/tb_m_xnor_vec_cmp.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_xnor_pkg.sv
// Shared types and helpers for the masked XNOR/XOR vector comparator.
package m_xnor_pkg;

    typedef enum logic {
        CMP_XNOR = 1'b0,
        CMP_XOR  = 1'b1
    } cmp_mode_e;

    // Width needed to hold a count of 0..w set bits.
    function automatic int sw_of(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/m_popcount.sv
// Combinational population count built as a balanced binary adder tree.
module m_popcount
    import m_xnor_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]        i_bits,
    output logic [sw_of(W)-1:0] o_count
);

    localparam int SW = sw_of(W);

    generate
        if (W == 1) begin : g_leaf
            assign o_count = SW'(i_bits);
        end else begin : g_tree
            // Split in halves so depth stays logarithmic in W.
            localparam int WL = W / 2;
            localparam int WH = W - WL;

            logic [sw_of(WL)-1:0] w_lo;
            logic [sw_of(WH)-1:0] w_hi;

            m_popcount #(.W(WL)) u_lo (
                .i_bits  (i_bits[WL-1:0]),
                .o_count (w_lo)
            );

            m_popcount #(.W(WH)) u_hi (
                .i_bits  (i_bits[W-1:WL]),
                .o_count (w_hi)
            );

            assign o_count = SW'(w_lo) + SW'(w_hi);
        end
    endgenerate

endmodule

// File: rtl/m_xnor_vec_cmp.sv
// Two-stage masked XNOR/XOR comparator with valid/ready flow control,
// threshold hit flag and a saturating hit counter.
module m_xnor_vec_cmp
    import m_xnor_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [W-1:0]        cfg_pattern,
    input  logic [W-1:0]        cfg_mask,
    input  logic [sw_of(W)-1:0] cfg_thresh,
    input  logic                cfg_mode,
    input  logic                clr_cnt,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [sw_of(W)-1:0] out_score,
    output logic                out_hit,
    output logic [CNT_W-1:0]    hit_cnt
);

    localparam int SW = sw_of(W);

    logic [W-1:0]     r_pattern;
    logic [W-1:0]     r_mask;
    logic [SW-1:0]    r_thresh;
    cmp_mode_e        r_mode;

    logic             r_s1_v;
    logic [W-1:0]     r_s1_bits;
    logic [SW-1:0]    r_s1_thresh;

    logic             r_s2_v;
    logic [SW-1:0]    r_s2_score;
    logic             r_s2_hit;

    logic [CNT_W-1:0] r_hit_cnt;

    logic [W-1:0]     w_s1_bits;
    logic [SW-1:0]    w_score;
    logic             w_hit;
    logic             w_accept;
    logic             w_adv;
    logic             w_consume;
    logic             w_cnt_max;

    // Either stage may take a beat as long as the pair is not full and stalled.
    assign in_ready  = !rst && (!r_s1_v || !r_s2_v || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_adv     = !r_s2_v || out_ready;
    assign w_consume = r_s2_v && out_ready;
    assign w_cnt_max = &r_hit_cnt;

    // Configuration registers; a same-cycle beat still sees the old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= {W{1'b0}};
            r_mask    <= {W{1'b1}};
            r_thresh  <= SW'(W);
            r_mode    <= CMP_XNOR;
        end else if (cfg_we) begin
            r_pattern <= cfg_pattern;
            r_mask    <= cfg_mask;
            r_thresh  <= cfg_thresh;
            r_mode    <= cmp_mode_e'(cfg_mode);
        end
    end

    // Bitwise agreement vector for the incoming word.
    always_comb begin
        w_s1_bits = {W{1'b0}};
        case (r_mode)
            CMP_XNOR: w_s1_bits = ~(in_data ^ r_pattern) & r_mask;
            CMP_XOR:  w_s1_bits =  (in_data ^ r_pattern) & r_mask;
            default:  w_s1_bits = {W{1'b0}};
        endcase
    end

    // Stage 1: masked compare result plus the threshold that travels with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v      <= 1'b0;
            r_s1_bits   <= {W{1'b0}};
            r_s1_thresh <= {SW{1'b0}};
        end else if (w_accept) begin
            r_s1_v      <= 1'b1;
            r_s1_bits   <= w_s1_bits;
            r_s1_thresh <= r_thresh;
        end else if (w_adv) begin
            r_s1_v      <= 1'b0;
        end
    end

    m_popcount #(.W(W)) u_popcount (
        .i_bits  (r_s1_bits),
        .o_count (w_score)
    );

    assign w_hit = (w_score >= r_s1_thresh);

    // Stage 2: score and hit, held steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v     <= 1'b0;
            r_s2_score <= {SW{1'b0}};
            r_s2_hit   <= 1'b0;
        end else if (w_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_score <= w_score;
                r_s2_hit   <= w_hit;
            end
        end
    end

    // Saturating count of consumed hits; clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            r_hit_cnt <= {CNT_W{1'b0}};
        end else if (w_consume && r_s2_hit && !w_cnt_max) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_s2_v;
    assign out_score = r_s2_score;
    assign out_hit   = r_s2_hit;
    assign hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_m_xnor_vec_cmp.sv
// Directed bench for m_xnor_vec_cmp with W = 8, CNT_W = 4.
module tb_m_xnor_vec_cmp;

    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int SW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [W-1:0]     cfg_pattern;
    logic [W-1:0]     cfg_mask;
    logic [SW-1:0]    cfg_thresh;
    logic             cfg_mode;
    logic             clr_cnt;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [SW-1:0]    out_score;
    logic             out_hit;
    logic [CNT_W-1:0] hit_cnt;

    int n_cmp   = 0;
    int n_bad   = 0;
    int exp_cnt = 0;

    typedef struct {
        bit         do_cfg;
        logic [7:0] pat;
        logic [7:0] mask;
        logic [3:0] thr;
        bit         mode;
        logic [7:0] data;
        int         score;
        bit         hit;
    } vec_t;

    vec_t tbl[12];

    m_xnor_vec_cmp #(.W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_thresh  (cfg_thresh),
        .cfg_mode    (cfg_mode),
        .clr_cnt     (clr_cnt),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_score   (out_score),
        .out_hit     (out_hit),
        .hit_cnt     (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic note_hit(input bit h);
        if (h && exp_cnt < 15) exp_cnt++;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [7:0] m, input logic [3:0] t, input bit md);
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_thresh  = t;
        cfg_mode    = md;
        cfg_we      = 1'b1;
        step();
        cfg_we      = 1'b0;
    endtask

    // One isolated beat: accept, check result two edges later, check counter after consume.
    task automatic run_vec(input vec_t v, input string tag);
        if (v.do_cfg) cfg(v.pat, v.mask, v.thr, v.mode);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v.data;
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        step();
        chk({tag, "_out_valid"}, int'(out_valid), 1);
        chk({tag, "_score"}, int'(out_score), v.score);
        chk({tag, "_hit"}, int'(out_hit), int'(v.hit));
        step();
        note_hit(v.hit);
        chk({tag, "_hit_cnt"}, int'(hit_cnt), exp_cnt);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_mask = 8'h00;
        cfg_thresh = 4'd0; cfg_mode = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; out_ready = 1'b0;

        //               cfg  pat    mask   thr   mode data   score hit
        tbl[0]  = '{1'b0, 8'h00, 8'hFF, 4'd8, 1'b0, 8'h00, 8, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 8'hFF, 4'd8, 1'b0, 8'h01, 7, 1'b0};
        tbl[2]  = '{1'b1, 8'hA5, 8'hFF, 4'd8, 1'b0, 8'hA5, 8, 1'b1};
        tbl[3]  = '{1'b1, 8'h00, 8'h0F, 4'd3, 1'b1, 8'hFF, 4, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 8'h0F, 4'd3, 1'b1, 8'h07, 3, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 8'h0F, 4'd3, 1'b1, 8'h01, 1, 1'b0};
        tbl[6]  = '{1'b1, 8'h00, 8'h00, 4'd0, 1'b0, 8'h5A, 0, 1'b1};
        tbl[7]  = '{1'b1, 8'h00, 8'h00, 4'd1, 1'b0, 8'h5A, 0, 1'b0};
        tbl[8]  = '{1'b1, 8'h3C, 8'hFF, 4'd9, 1'b0, 8'h3C, 8, 1'b0};
        tbl[9]  = '{1'b1, 8'hF0, 8'hFF, 4'd0, 1'b0, 8'h0F, 0, 1'b1};
        tbl[10] = '{1'b1, 8'h00, 8'hAA, 4'd2, 1'b0, 8'h0F, 2, 1'b1};
        tbl[11] = '{1'b1, 8'h55, 8'hFF, 4'd8, 1'b1, 8'hAA, 8, 1'b1};

        // Reset state
        step();
        step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_score", int'(out_score), 0);
        chk("rst_out_hit", int'(out_hit), 0);
        chk("rst_hit_cnt", int'(hit_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

        // Output stall: two beats accepted, then back-pressure, then ordered drain
        cfg(8'h00, 8'hFF, 4'd4, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        chk("stall_rdy0", int'(in_ready), 1);
        step();
        in_data = 8'hFF;
        chk("stall_rdy1", int'(in_ready), 1);
        step();
        chk("stall_rdy_full", int'(in_ready), 0);
        chk("stall_valid", int'(out_valid), 1);
        in_data = 8'h0F;
        step();
        step();
        chk("stall_rdy_hold", int'(in_ready), 0);
        chk("stall_score_hold", int'(out_score), 8);
        chk("stall_hit_hold", int'(out_hit), 1);
        out_ready = 1'b1;
        #1;
        chk("stall_rdy_release", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        note_hit(1'b1);
        chk("drain1_valid", int'(out_valid), 1);
        chk("drain1_score", int'(out_score), 0);
        chk("drain1_hit", int'(out_hit), 0);
        step();
        chk("drain2_valid", int'(out_valid), 1);
        chk("drain2_score", int'(out_score), 4);
        chk("drain2_hit", int'(out_hit), 1);
        chk("drain2_cnt", int'(hit_cnt), exp_cnt);
        step();
        note_hit(1'b1);
        chk("drain_empty", int'(out_valid), 0);
        chk("drain_cnt", int'(hit_cnt), exp_cnt);

        // Reconfiguration in the same cycle as an accepted beat
        cfg(8'h00, 8'hFF, 4'd8, 1'b0);
        cfg_thresh = 4'd0;
        cfg_we     = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h01;
        step();
        cfg_we  = 1'b0;
        in_data = 8'hFF;
        step();
        in_valid = 1'b0;
        chk("race_b1_score", int'(out_score), 7);
        chk("race_b1_hit", int'(out_hit), 0);
        step();
        note_hit(1'b0);
        chk("race_b2_score", int'(out_score), 0);
        chk("race_b2_hit", int'(out_hit), 1);
        step();
        note_hit(1'b1);
        chk("race_cnt", int'(hit_cnt), exp_cnt);

        // 20 back-to-back hits at full throughput; counter saturates
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'(i);
            chk($sformatf("tput_rdy%0d", i), int'(in_ready), 1);
            if (i >= 2) chk($sformatf("tput_val%0d", i), int'(out_valid), 1);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 20; i++) note_hit(1'b1);
        chk("sat_cnt", int'(hit_cnt), exp_cnt);
        chk("sat_cnt_15", int'(hit_cnt), 15);
        chk("sat_drained", int'(out_valid), 0);

        // Clear coincident with a consumed hit
        in_valid = 1'b1;
        in_data  = 8'h00;
        step();
        in_valid = 1'b0;
        step();
        chk("clr_hit_pending", int'(out_hit), 1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        exp_cnt = 0;
        chk("clr_cnt", int'(hit_cnt), 0);
        v = '{1'b0, 8'h00, 8'hFF, 4'd0, 1'b0, 8'h00, 8, 1'b1};
        run_vec(v, "after_clr");

        // Reset with both stages full
        cfg(8'hFF, 8'h0F, 4'd2, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        step();
        step();
        in_valid = 1'b0;
        chk("full_valid", int'(out_valid), 1);
        chk("full_rdy", int'(in_ready), 0);
        rst = 1'b1;
        step();
        exp_cnt = 0;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_score", int'(out_score), 0);
        chk("midrst_hit", int'(out_hit), 0);
        chk("midrst_rdy", int'(in_ready), 0);
        chk("midrst_cnt", int'(hit_cnt), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_rdy_after", int'(in_ready), 1);
        step();
        step();
        chk("midrst_no_beat", int'(out_valid), 0);
        v = '{1'b0, 8'h00, 8'hFF, 4'd8, 1'b0, 8'h00, 8, 1'b1};
        run_vec(v, "cfg_restored");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
